mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: widths, len encodings
// and request flag bit positions.
package mem_ctrl_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [1:0] LEN_1B   = 2'd0;
    localparam logic [1:0] LEN_2B   = 2'd1;
    localparam logic [1:0] LEN_RSVD = 2'd2;
    localparam logic [1:0] LEN_4B   = 2'd3;

    localparam int RW_READ_BIT  = 0;
    localparam int RW_WRITE_BIT = 1;

    // The reserved encoding is served as a full word rather than rejected.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len_code);
        return (len_code == LEN_RSVD) ? 3'd4 : ({1'b0, len_code} + 3'd1);
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits 1/2/4-byte cache loads and stores into
// single-byte RAM accesses, with a global rdy stall.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = INST_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic [1:0]        rw_flag,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        len,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_busy,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;       // edges elapsed since acceptance
    logic [2:0]        nbytes_reg, nbytes_next;
    logic [2:0]        step;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rbuf_reg, rbuf_next;
    logic [DATA_W-1:0] read_data_reg, read_data_next;
    logic [7:0]        ram_dout_reg, ram_dout_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              ram_wr_reg, ram_wr_next;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        nbytes_next    = nbytes_reg;
        addr_next      = addr_reg;
        ram_a_next     = ram_a_reg;
        wdata_next     = wdata_reg;
        rbuf_next      = rbuf_reg;
        read_data_next = read_data_reg;
        ram_dout_next  = ram_dout_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        ram_wr_next    = 1'b0;
        step           = cnt_reg + 3'd1;

        case (state_reg)
            IDLE: begin
                if (rw_flag != 2'b00) begin
                    cnt_next    = 3'd0;
                    busy_next   = 1'b1;
                    addr_next   = addr;
                    ram_a_next  = addr;
                    nbytes_next = len_to_nbytes(len);
                    wdata_next  = write_data;
                    rbuf_next   = '0;
                    if (rw_flag[RW_READ_BIT]) begin
                        state_next = READ;
                    end else begin
                        state_next    = WRITE;
                        ram_wr_next   = 1'b1;
                        ram_dout_next = write_data[7:0];
                    end
                end
            end
            READ: begin
                cnt_next = step;
                if (step < nbytes_reg)
                    ram_a_next = addr_reg + ADDR_W'(step);
                // RAM returns the byte two edges after its address was registered.
                for (int b = 0; b < NB; b++)
                    if (step == 3'(b + 2))
                        rbuf_next[8*b +: 8] = ram_din;
                if (step == nbytes_reg + 3'd1) begin
                    state_next     = IDLE;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                    read_data_next = rbuf_next;
                end
            end
            WRITE: begin
                cnt_next = step;
                if (step < nbytes_reg) begin
                    ram_a_next  = addr_reg + ADDR_W'(step);
                    ram_wr_next = 1'b1;
                    for (int b = 0; b < NB; b++)
                        if (step == 3'(b))
                            ram_dout_next = wdata_reg[8*b +: 8];
                end else begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            nbytes_reg    <= '0;
            addr_reg      <= '0;
            ram_a_reg     <= '0;
            wdata_reg     <= '0;
            rbuf_reg      <= '0;
            read_data_reg <= '0;
            ram_dout_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ram_wr_reg    <= 1'b0;
        end else if (rdy) begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            nbytes_reg    <= nbytes_next;
            addr_reg      <= addr_next;
            ram_a_reg     <= ram_a_next;
            wdata_reg     <= wdata_next;
            rbuf_reg      <= rbuf_next;
            read_data_reg <= read_data_next;
            ram_dout_reg  <= ram_dout_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ram_wr_reg    <= ram_wr_next;
        end
    end

    // A stalled write strobe is masked, not dropped, so it reissues when rdy returns.
    assign ram_wr    = ram_wr_reg & rdy;
    assign read_data = read_data_reg;
    assign mem_busy  = busy_reg;
    assign mem_done  = done_reg;
    assign ram_a     = ram_a_reg;
    assign ram_dout  = ram_dout_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a 256-byte synchronous RAM model indexed
// by the low address byte.
module tb_mem_ctrl;
    logic        clk, rst_n, rdy;
    logic [1:0]  rw_flag, len;
    logic [31:0] addr, write_data, read_data, ram_a;
    logic        mem_busy, mem_done, ram_wr;
    logic [7:0]  ram_din, ram_dout;

    logic [7:0]  ram_mem [256];
    logic        pl_en;
    logic [7:0]  pl_a, pl_d;
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          wr_base;
    logic        done_seen;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rw_flag(rw_flag), .addr(addr),
        .len(len), .write_data(write_data), .read_data(read_data),
        .mem_busy(mem_busy), .mem_done(mem_done), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        ram_din <= ram_mem[ram_a[7:0]];
        if (pl_en) begin
            ram_mem[pl_a] <= pl_d;
        end else if (ram_wr) begin
            ram_mem[ram_a[7:0]] <= ram_dout;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Returns in the cycle right after the acceptance edge.
    task automatic do_req(input logic [1:0] rw, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] wd);
        @(negedge clk);
        rw_flag = rw; addr = a; len = l; write_data = wd;
        @(negedge clk);
        rw_flag = 2'b00;
        $display("txn rw=%b addr=0x%08h len=%0d wdata=0x%08h", rw, a, l, wd);
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (!mem_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!mem_done) check("done_timeout", 32'(mem_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rw_flag = 2'b00; addr = '0; len = '0;
        write_data = '0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        preload(8'h40, 8'h11); preload(8'h41, 8'h22);
        preload(8'h42, 8'h33); preload(8'h43, 8'h44);
        preload(8'hFF, 8'h5A); preload(8'h00, 8'hC3);
        preload(8'h90, 8'h00);
        @(negedge clk);
        check("rst_busy", 32'(mem_busy), 0);
        check("rst_done", 32'(mem_done), 0);
        check("rst_rdata", read_data, 0);
        check("rst_ram_a", ram_a, 0);
        check("rst_ram_wr", 32'(ram_wr), 0);
        rst_n = 1'b1;

        // Aligned 4-byte load
        do_req(2'b01, 32'h140, 2'd3, 0);
        check("rd4_busy", 32'(mem_busy), 1);
        check("rd4_ram_a0", ram_a, 32'h140);
        wait_done(0, cyc);
        check("rd4_lat", cyc, 5);
        check("rd4_data", read_data, 32'h44332211);
        check("rd4_busy_done", 32'(mem_busy), 0);

        // Single byte store, then read it back
        wr_base = wr_cnt;
        do_req(2'b10, 32'h7, 2'd0, 32'h000000A5);
        check("wr1_ram_wr", 32'(ram_wr), 1);
        check("wr1_ram_a", ram_a, 32'h7);
        check("wr1_dout", 32'(ram_dout), 32'hA5);
        wait_done(0, cyc);
        check("wr1_lat", cyc, 1);
        check("wr1_rdata_kept", read_data, 32'h44332211);
        @(negedge clk);
        check("wr1_count", wr_cnt - wr_base, 1);
        check("wr1_idle_wr", 32'(ram_wr), 0);
        do_req(2'b01, 32'h7, 2'd0, 0);
        wait_done(0, cyc);
        check("rd1_data", read_data, 32'h000000A5);
        check("rd1_lat", cyc, 2);

        // Address wrap across the top of the space
        do_req(2'b01, 32'hFFFFFFFF, 2'd1, 0);
        check("wrap_a0", ram_a, 32'hFFFFFFFF);
        @(negedge clk);
        check("wrap_a1", ram_a, 32'h00000000);
        wait_done(1, cyc);
        check("wrap_lat", cyc, 3);
        check("wrap_data", read_data, 32'h0000C35A);

        // Reserved len code behaves as a word; rw=11 counts as a read
        do_req(2'b11, 32'h140, 2'd2, 0);
        wait_done(0, cyc);
        check("len2_lat", cyc, 5);
        check("len2_data", read_data, 32'h44332211);

        // Request during busy is ignored; request in the done cycle is accepted
        wr_base = wr_cnt;
        do_req(2'b01, 32'h140, 2'd0, 0);
        rw_flag = 2'b10; addr = 32'h90; len = 2'd0; write_data = 32'hEE;
        @(negedge clk);
        rw_flag = 2'b00;
        wait_done(1, cyc);
        check("b2b_lat1", cyc, 2);
        check("b2b_data1", read_data, 32'h00000011);
        rw_flag = 2'b01; addr = 32'h141; len = 2'd0;
        @(negedge clk);
        rw_flag = 2'b00;
        check("b2b_ram_a", ram_a, 32'h141);
        check("b2b_busy", 32'(mem_busy), 1);
        wait_done(0, cyc);
        check("b2b_lat2", cyc, 2);
        check("b2b_data2", read_data, 32'h00000022);
        check("busy_ignored_wr", wr_cnt - wr_base, 0);
        check("busy_ignored_mem", 32'(ram_mem[8'h90]), 0);

        // Three-cycle rdy stall in the middle of a word store
        wr_base = wr_cnt;
        do_req(2'b10, 32'h80, 2'd3, 32'hDDCCBBAA);
        check("stall_wr_c0", 32'(ram_wr), 1);
        @(negedge clk);
        check("stall_ram_a1", ram_a, 32'h81);
        rdy = 1'b0;
        #1 check("stall_mask0", 32'(ram_wr), 0);
        repeat (2) begin
            @(negedge clk);
            check("stall_mask", 32'(ram_wr), 0);
            check("stall_hold_a", ram_a, 32'h81);
        end
        @(negedge clk);
        rdy = 1'b1;
        wait_done(4, cyc);
        check("stall_lat", cyc, 7);
        @(negedge clk);
        check("stall_wr_count", wr_cnt - wr_base, 4);
        check("stall_b0", 32'(ram_mem[8'h80]), 32'hAA);
        check("stall_b1", 32'(ram_mem[8'h81]), 32'hBB);
        check("stall_b2", 32'(ram_mem[8'h82]), 32'hCC);
        check("stall_b3", 32'(ram_mem[8'h83]), 32'hDD);

        // Asynchronous reset in the middle of a load
        do_req(2'b01, 32'h140, 2'd3, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(mem_busy), 0);
        check("abort_ram_a", ram_a, 0);
        check("abort_rdata", read_data, 0);
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_done) done_seen = 1'b1;
        end
        check("abort_nodone", 32'(done_seen), 0);
        rst_n = 1'b1;
        do_req(2'b01, 32'h143, 2'd0, 0);
        wait_done(0, cyc);
        check("post_abort_lat", cyc, 2);
        check("post_abort_data", read_data, 32'h00000044);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
